// File: rtl/capture_buffer.sv
// Triggered capture of decimated ADC samples into a circular RAM, read back oldest-first one byte per PIC request.
// Writes take no latency; readout byte appears 2 cycles after READ entry or consume; rd_rdy drops 3 cycles after a rd_req rise.
module capture_buffer #(
  parameter int DEPTH   = 1024,
  parameter int PRETRIG = 256
) (
  input  logic       decim_clk,
  input  logic       rst_n,
  input  logic [7:0] adc_data,
  input  logic       arm,
  input  logic       abort,
  input  logic       trig,
  input  logic       rd_req,
  output logic [7:0] rd_data,
  output logic       rd_rdy,
  output logic       busy,
  output logic       triggered,
  output logic       done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRETRIG - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRETRIG);
  localparam logic [AW-1:0] POST_INIT = AW'(DEPTH - PRETRIG - 1);
  localparam logic [AW-1:0] CNT_LAST  = AW'(DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    ram_rd_q;
  logic          wr_en;
  logic          go_read;
  logic          trig_edge;
  logic          req_edge;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] post_cnt_q, post_cnt_d;
  logic [AW-1:0] start_ptr_q, start_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_cnt_q, rd_cnt_d;
  logic          trig_q, trig_d;
  logic          req_s1_q, req_s1_d;
  logic          req_s2_q, req_s2_d;
  logic          req_s3_q, req_s3_d;
  logic          fetch1_q, fetch1_d;
  logic          fetch2_q, fetch2_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_rdy_q, rd_rdy_d;
  logic          busy_q, busy_d;
  logic          triggered_q, triggered_d;
  logic          done_q, done_d;

  // RAM has no reset; the read port runs every cycle and is only consumed via the fetch pipeline
  always_ff @(posedge decim_clk) begin
    if (wr_en) mem[wr_ptr_q] <= adc_data;
    ram_rd_q <= mem[rd_ptr_q];
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    post_cnt_d  = post_cnt_q;
    start_ptr_d = start_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_cnt_d    = rd_cnt_q;
    trig_d      = trig;
    req_s1_d    = rd_req;
    req_s2_d    = req_s1_q;
    req_s3_d    = req_s2_q;
    fetch1_d    = 1'b0;
    fetch2_d    = fetch1_q;
    rd_data_d   = rd_data_q;
    rd_rdy_d    = rd_rdy_q;
    triggered_d = triggered_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    go_read     = 1'b0;
    trig_edge   = trig & ~trig_q;
    req_edge    = req_s2_q & ~req_s3_q;

    if (abort) begin
      state_d     = S_IDLE;
      rd_rdy_d    = 1'b0;
      triggered_d = 1'b0;
      fetch2_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d  = S_PRE;
            wr_ptr_d = '0;
            cnt_d    = '0;
          end
        end
        S_PRE: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q + AW'(1);
          if (cnt_q == PRE_LAST) state_d = S_ARMED;
        end
        S_ARMED: begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          // the sample written in the edge cycle is the trigger sample
          if (trig_edge) begin
            start_ptr_d = wr_ptr_q - PRE_OFS;
            triggered_d = 1'b1;
            post_cnt_d  = POST_INIT;
            if (POST_INIT == '0) go_read = 1'b1;
            else                 state_d = S_POST;
          end
        end
        S_POST: begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + AW'(1);
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) go_read = 1'b1;
        end
        S_READ: begin
          if (fetch2_q) begin
            rd_data_d = ram_rd_q;
            rd_rdy_d  = 1'b1;
          end
          if (req_edge && rd_rdy_q) begin
            rd_rdy_d = 1'b0;
            rd_ptr_d = rd_ptr_q + AW'(1);
            rd_cnt_d = rd_cnt_q + AW'(1);
            if (rd_cnt_q == CNT_LAST) begin
              done_d      = 1'b1;
              triggered_d = 1'b0;
              state_d     = S_IDLE;
            end else begin
              fetch1_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (go_read) begin
        state_d  = S_READ;
        rd_ptr_d = start_ptr_d;
        rd_cnt_d = '0;
        fetch1_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge decim_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      post_cnt_q  <= '0;
      start_ptr_q <= '0;
      rd_ptr_q    <= '0;
      rd_cnt_q    <= '0;
      trig_q      <= 1'b0;
      req_s1_q    <= 1'b0;
      req_s2_q    <= 1'b0;
      req_s3_q    <= 1'b0;
      fetch1_q    <= 1'b0;
      fetch2_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_rdy_q    <= 1'b0;
      busy_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      post_cnt_q  <= post_cnt_d;
      start_ptr_q <= start_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_cnt_q    <= rd_cnt_d;
      trig_q      <= trig_d;
      req_s1_q    <= req_s1_d;
      req_s2_q    <= req_s2_d;
      req_s3_q    <= req_s3_d;
      fetch1_q    <= fetch1_d;
      fetch2_q    <= fetch2_d;
      rd_data_q   <= rd_data_d;
      rd_rdy_q    <= rd_rdy_d;
      busy_q      <= busy_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_rdy    = rd_rdy_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
endmodule
